// File: rtl/divider_s_pkg.sv
// Shared ALU definitions for the sequential divider: default width, FSM encoding
// and the iteration-counter sizing rule.
package divider_s_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // The counter must hold WIDTH-1 with room to spare.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/divider_s_div_step.sv
// One restoring shift-subtract iteration: shift {R,Q} left, subtract D from R
// when it fits, and record the outcome in the new quotient LSB.
module div_step
  import divider_s_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   r_sh;
  logic             fits;

  assign r_sh = {r_i, q_i[WIDTH-1]};
  assign fits = (r_sh >= {1'b0, d_i});

  // When D fits, the difference is below D, so the low WIDTH bits are exact.
  assign r_o = fits ? (r_sh[WIDTH-1:0] - d_i) : r_sh[WIDTH-1:0];
  assign q_o = {q_i[WIDTH-2:0], fits};

endmodule

// File: rtl/divider_s.sv
// Sequential signed/unsigned divider: sign-magnitude capture, WIDTH restoring
// iterations, then a sign-fix cycle that loads the registered results.
module divider_s
  import divider_s_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic             IS_SIGNED,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_BY_ZERO
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] r_step, q_step;
  logic             sd, sv, dbz;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_step),
    .q_o (q_step)
  );

  assign sd  = IS_SIGNED & DIVIDEND[WIDTH-1];
  assign sv  = IS_SIGNED & DIVISOR[WIDTH-1];
  assign dbz = (d_q == '0);

  // NOTE: every next-state signal is given its hold value first so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          r_d     = '0;
          // Magnitudes stay unsigned, so negating -2^(WIDTH-1) is exact.
          q_d     = sd ? -DIVIDEND : DIVIDEND;
          d_d     = sv ? -DIVISOR  : DIVISOR;
          q_neg_d = sd ^ sv;
          r_neg_d = sd;
        end
      end

      ST_RUN: begin
        r_d = r_step;
        q_d = q_step;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FIX: begin
        // A zero divisor leaves Q all ones and R = |DIVIDEND|; re-signing R
        // restores DIVIDEND, while Q is pinned to all ones in both modes.
        quot_d  = dbz ? '1 : (q_neg_q ? -q_q : q_q);
        rem_d   = r_neg_q ? -r_q : r_q;
        dbz_d   = dbz;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign QUOTIENT    = quot_q;
  assign REMAINDER   = rem_q;
  assign DONE        = done_q;
  assign DIV_BY_ZERO = dbz_q;
  assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_divider_s.sv
// Self-checking bench for divider_s: directed spec vectors, handshake cases and
// random operands checked against plain-arithmetic division.
module tb_divider_s;

  localparam int W       = 32;
  localparam int LATENCY = 33;  // DONE seen after edge E0+33 (edges E0..E33 inclusive = 34)

  logic         clk = 1'b0;
  logic         rst;
  logic         START;
  logic         IS_SIGNED;
  logic [W-1:0] DIVIDEND;
  logic [W-1:0] DIVISOR;
  logic [W-1:0] QUOTIENT;
  logic [W-1:0] REMAINDER;
  logic         BUSY;
  logic         DONE;
  logic         DIV_BY_ZERO;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;

  divider_s #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .START       (START),
    .IS_SIGNED   (IS_SIGNED),
    .DIVIDEND    (DIVIDEND),
    .DIVISOR     (DIVISOR),
    .QUOTIENT    (QUOTIENT),
    .REMAINDER   (REMAINDER),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .DIV_BY_ZERO (DIV_BY_ZERO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: language-level division, with the divide-by-zero rule layered on.
  task automatic model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  // Present an operation and let the next rising edge accept it.
  task automatic start_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    START = 1'b1; IS_SIGNED = sgn; DIVIDEND = a; DIVISOR = b;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    START = 1'b0;
  endtask

  // Wait (bounded) for DONE; check BUSY on the way, latency and results at DONE.
  task automatic wait_done(input string tag, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input logic ez);
    for (int i = 0; i < LATENCY + 10; i++) begin
      if (DONE) break;
      check({tag, ".busy"}, W'(BUSY), W'(1));
      @(posedge clk);
      #1;
    end
    check({tag, ".done"}, W'(DONE), W'(1));
    check({tag, ".latency"}, W'(cyc - start_cyc), W'(LATENCY));
    check({tag, ".busy_at_done"}, W'(BUSY), W'(0));
    check({tag, ".quotient"}, QUOTIENT, eq);
    check({tag, ".remainder"}, REMAINDER, er);
    check({tag, ".dbz"}, W'(DIV_BY_ZERO), W'(ez));
  endtask

  // After a DONE with no new START: pulse must end and results must hold.
  task automatic check_quiet(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".done_low"}, W'(DONE), W'(0));
    check({tag, ".idle"}, W'(BUSY), W'(0));
    check({tag, ".q_hold"}, QUOTIENT, eq);
    check({tag, ".r_hold"}, REMAINDER, er);
  endtask

  task automatic do_op(input string tag, input logic sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input logic ez);
    @(negedge clk);
    start_op(sgn, a, b);
    wait_done(tag, eq, er, ez);
    check_quiet(tag, eq, er);
  endtask

  initial begin
    logic [W-1:0] a, b, mq, mr;
    logic         mz, sg;

    rst = 1'b1; START = 1'b0; IS_SIGNED = 1'b0; DIVIDEND = '0; DIVISOR = '0;
    #12;
    check("reset.quotient", QUOTIENT, '0);
    check("reset.remainder", REMAINDER, '0);
    check("reset.busy", W'(BUSY), W'(0));
    check("reset.done", W'(DONE), W'(0));
    check("reset.dbz", W'(DIV_BY_ZERO), W'(0));
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with hand-derived results.
    do_op("s6_2",     1'b1, 32'd6,          32'd2,          32'd3,          32'd0,          1'b0);
    do_op("sm1_2",    1'b1, 32'hFFFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFF,  1'b0);
    do_op("um1_2",    1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0);
    do_op("sm7_m13",  1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFF3,  32'd0,          32'hFFFF_FFF9,  1'b0);
    do_op("s7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
    do_op("sm7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
    do_op("ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
    do_op("u5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1);
    do_op("sm5_0",    1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1);

    // START held with changing operands while busy: first result must stand.
    @(negedge clk);
    start_op(1'b0, 32'd100, 32'd7);
    START = 1'b1;
    for (int i = 0; i < 20; i++) begin
      IS_SIGNED = i[0]; DIVIDEND = $urandom; DIVISOR = $urandom;
      @(posedge clk);
      #1;
    end
    START = 1'b0;
    wait_done("held", 32'd14, 32'd2, 1'b0);
    check_quiet("held", 32'd14, 32'd2);

    // Back-to-back: second START presented in the DONE cycle.
    @(negedge clk);
    start_op(1'b1, 32'hFFFF_FF9C, 32'd9);                // -100 / 9
    wait_done("b2b_a", 32'hFFFF_FFF5, 32'hFFFF_FFFF, 1'b0);
    start_op(1'b0, 32'd1000, 32'd33);
    wait_done("b2b_b", 32'd30, 32'd10, 1'b0);
    check_quiet("b2b_b", 32'd30, 32'd10);

    // Reset at RUN counter 10 aborts the operation without a DONE.
    @(negedge clk);
    start_op(1'b0, 32'd12345, 32'd67);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort.quotient", QUOTIENT, '0);
    check("abort.remainder", REMAINDER, '0);
    check("abort.busy", W'(BUSY), W'(0));
    check("abort.done", W'(DONE), W'(0));
    check("abort.dbz", W'(DIV_BY_ZERO), W'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      check("abort.no_done", W'(DONE), W'(0));
    end
    do_op("after_abort", 1'b0, 32'd12345, 32'd67, 32'd184, 32'd17, 1'b0);

    // Random operands against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      sg = 1'(i % 2);
      a  = $urandom;
      b  = $urandom;
      if (i % 3 == 0) b = W'($urandom_range(1, 40));
      if (i % 6 == 3) b = -W'($urandom_range(1, 40));
      if (i == 11)    b = '0;
      model(sg, a, b, mq, mr, mz);
      do_op($sformatf("rand%0d", i), sg, a, b, mq, mr, mz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
